stream_demux_1xn: RTL and testbench

Parametrised, registered 1-to-N demultiplexer with valid/ready flow control. It is the clocked successor of the combinational 1x4 DEMUX: one input stream of WIDTH-bit beats is steered to one of N_CH output channels. Each channel has a one-entry output register. Routing is by explicit select or by an internal round-robin pointer. It sits between a single producer and N_CH independent consumers.

---
 rtl/stream_demux_1xn_pkg.sv | 11 +
 rtl/stream_demux_1xn_if.sv | 43 ++++
 rtl/stream_demux_1xn_slot.sv | 28 ++
 rtl/stream_demux_1xn.sv | 102 ++++++++++
 tb/tb_stream_demux_1xn.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_1xn_pkg.sv
// stream_demux_1xn shared definitions.
// Mode encodings and parameter limits.
package stream_demux_1xn_pkg;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_SEQ      = 1'b1;

  localparam int MIN_CH = 2;
  localparam int MAX_CH = 16;

endpackage

// File: rtl/stream_demux_1xn_if.sv
// stream_demux_1xn producer/consumer bundle.
// master drives beats and out_ready, slave is the demux.
interface stream_demux_1xn_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);

  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    mode;
  logic                    in_ready;
  logic [N_CH-1:0]         out_valid;
  logic [N_CH*WIDTH-1:0]   out_data;
  logic [N_CH-1:0]         out_ready;
  logic                    err;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output err
  );

endinterface

// File: rtl/stream_demux_1xn_slot.sv
// demux_slot: one-entry output register.
// A load wins over a drain in the same cycle.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // load sets valid with new data, drain clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N stream demux.
// Optional macro DEMUX_OOR_ERR_EN enables the err pulse.
module stream_demux_1xn
  import stream_demux_1xn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input logic               clk,
  input logic               rst,
  stream_demux_1xn_if.slave bus
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] tgt;
  logic             in_rng;
  logic             tgt_full;
  logic             tgt_rdy;
  logic             accept;
  logic [N_CH-1:0]  load;

  if (((1 << SEL_W) < N_CH) ||
      (N_CH < MIN_CH) || (N_CH > MAX_CH) ||
      (WIDTH < 1)) begin : g_bad_param
    $error("stream_demux_1xn: illegal WIDTH/N_CH/SEL_W");
  end

  assign tgt = (bus.mode == MODE_SEQ) ?
               ptr : bus.in_sel;

  assign in_rng = {1'b0, tgt} <
                  (SEL_W+1)'(N_CH);

  // pick full/ready of the targeted slot
  always_comb begin
    tgt_full = 1'b0;
    tgt_rdy  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) begin
        tgt_full = bus.out_valid[k];
        tgt_rdy  = bus.out_ready[k];
      end
    end
  end

  // out-of-range beats are always swallowed
  assign bus.in_ready = !in_rng ||
                        !tgt_full ||
                        tgt_rdy;

  assign accept = bus.in_valid &&
                  bus.in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign load[k] = accept && in_rng &&
                     (tgt == SEL_W'(k));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (bus.in_data),
      .drain (bus.out_ready[k]),
      .valid (bus.out_valid[k]),
      .dout  (bus.out_data[k*WIDTH +: WIDTH])
    );
  end

  // round-robin pointer, moves on sequential accepts only
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept &&
                 bus.mode == MODE_SEQ) begin
      if (ptr == SEL_W'(N_CH-1))
        ptr <= '0;
      else
        ptr <= ptr + 1'b1;
    end
  end

`ifdef DEMUX_OOR_ERR_EN
  logic err_q;

  // one-cycle pulse per discarded directed beat
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= accept && !in_rng &&
               (bus.mode == MODE_DIRECTED);
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// stream_demux_1xn bench: 4-channel vector table
// plus reset and out-of-range sequences on a 3-channel copy.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

`ifdef DEMUX_OOR_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  stream_demux_1xn_if #(.WIDTH(8), .N_CH(4), .SEL_W(2)) b4 ();
  stream_demux_1xn_if #(.WIDTH(8), .N_CH(3), .SEL_W(2)) b3 ();

  stream_demux_1xn #(.WIDTH(8), .N_CH(4), .SEL_W(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  stream_demux_1xn #(.WIDTH(8), .N_CH(3), .SEL_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  typedef struct {
    logic       mode;
    logic       valid;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   mptr = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];

  task automatic add(input logic m, input logic v,
                     input logic [1:0] s,
                     input logic [7:0] d,
                     input logic [3:0] r,
                     input logic y,
                     input logic [3:0] o);
    vec_t t;
    t.mode = m; t.valid = v; t.sel = s; t.data = d;
    t.ordy = r; t.rdy = y; t.ov = o;
    vt.push_back(t);
  endtask

  initial begin
    exp_t e;
    int ch;
    b4.in_valid = 0; b4.in_data = 0; b4.in_sel = 0;
    b4.mode = 0; b4.out_ready = 4'hF;
    b3.in_valid = 0; b3.in_data = 0; b3.in_sel = 0;
    b3.mode = 0; b3.out_ready = 3'h7;

    // directed sweep, same-channel back-to-back
    add(0, 1, 2, 8'hA5, 4'hF, 1, 4'b0100);
    add(0, 1, 0, 8'h01, 4'hF, 1, 4'b0001);
    add(0, 1, 1, 8'h02, 4'hF, 1, 4'b0010);
    add(0, 1, 2, 8'h03, 4'hF, 1, 4'b0100);
    add(0, 1, 3, 8'h04, 4'hF, 1, 4'b1000);
    add(0, 1, 3, 8'h09, 4'hF, 1, 4'b1000);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000);
    // backpressure on channel 1
    add(0, 1, 1, 8'h11, 4'hD, 1, 4'b0010);
    add(0, 1, 1, 8'h22, 4'hD, 0, 4'b0010);
    add(0, 1, 1, 8'h22, 4'hF, 1, 4'b0010);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000);
    // sequential wrap then mode switch
    add(1, 1, 0, 8'h00, 4'hF, 1, 4'b0001);
    add(1, 1, 0, 8'h01, 4'hF, 1, 4'b0010);
    add(1, 1, 0, 8'h02, 4'hF, 1, 4'b0100);
    add(1, 1, 0, 8'h03, 4'hF, 1, 4'b1000);
    add(1, 1, 0, 8'h04, 4'hF, 1, 4'b0001);
    add(1, 1, 0, 8'h05, 4'hF, 1, 4'b0010);
    add(0, 1, 0, 8'h06, 4'hF, 1, 4'b0001);
    add(1, 1, 3, 8'h07, 4'hF, 1, 4'b0100);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000);

    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_ov4", 32'(b4.out_valid), 0);
    chk("rst_od4", 32'(b4.out_data), 0);
    chk("rst_err4", 32'(b4.err), 0);
    chk("rst_rdy4", 32'(b4.in_ready), 1);
    chk("rst_ov3", 32'(b3.out_valid), 0);
    chk("rst_err3", 32'(b3.err), 0);

    foreach (vt[i]) begin
      b4.mode      = vt[i].mode;
      b4.in_valid  = vt[i].valid;
      b4.in_sel    = vt[i].sel;
      b4.in_data   = vt[i].data;
      b4.out_ready = vt[i].ordy;
      #1;
      chk($sformatf("rdy[%0d]", i),
          32'(b4.in_ready), 32'(vt[i].rdy));
      if (vt[i].valid && vt[i].rdy) begin
        ch = vt[i].mode ? mptr : int'(vt[i].sel);
        e.ch = ch; e.data = vt[i].data;
        sb.push_back(e);
        if (vt[i].mode)
          mptr = (mptr == 3) ? 0 : mptr + 1;
      end
      tick();
      chk($sformatf("ov[%0d]", i),
          32'(b4.out_valid), 32'(vt[i].ov));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("od[%0d]", i),
            32'(b4.out_data[e.ch*8 +: 8]),
            32'(e.data));
      end
    end
    chk("mptr_end", mptr, 3);
    chk("err4_idle", 32'(b4.err), 0);

    // channel 0 stalled, ptr=3, then reset
    b4.mode = 0; b4.in_sel = 0; b4.in_valid = 1;
    b4.in_data = 8'h55; b4.out_ready = 4'b1110;
    #1;
    chk("stall_rdy", 32'(b4.in_ready), 1);
    tick();
    chk("stall_ov", 32'(b4.out_valid), 32'h1);
    chk("stall_od", 32'(b4.out_data[7:0]), 32'h55);
    b4.mode = 1; b4.in_data = 8'h66; rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_ov", 32'(b4.out_valid), 0);
    chk("mid_rst_od", 32'(b4.out_data), 0);
    b4.in_data = 8'h77; b4.out_ready = 4'hF;
    tick();
    chk("post_rst_ov", 32'(b4.out_valid), 32'h1);
    chk("post_rst_od", 32'(b4.out_data[7:0]), 32'h77);
    b4.in_valid = 0;

    // out-of-range select on the 3-channel copy
    b3.mode = 0; b3.in_sel = 3; b3.in_data = 8'hFF;
    b3.in_valid = 1;
    #1;
    chk("oor_rdy", 32'(b3.in_ready), 1);
    tick();
    b3.in_valid = 0;
    chk("oor_ov", 32'(b3.out_valid), 0);
    chk("oor_err", 32'(b3.err), 32'(EXP_ERR));
    tick();
    chk("oor_err_end", 32'(b3.err), 0);
    b3.in_valid = 1;
    tick();
    chk("oor_b2b_0", 32'(b3.err), 32'(EXP_ERR));
    tick();
    chk("oor_b2b_1", 32'(b3.err), 32'(EXP_ERR));
    chk("oor_b2b_ov", 32'(b3.out_valid), 0);
    b3.in_sel = 2; b3.in_data = 8'h3C;
    tick();
    chk("oor_good_ov", 32'(b3.out_valid), 32'h4);
    chk("oor_good_od", 32'(b3.out_data[23:16]), 32'h3C);
    chk("oor_good_err", 32'(b3.err), 0);

    // sequential wrap at a non-power-of-two count
    b3.mode = 1;
    for (int i = 0; i < 4; i++) begin
      b3.in_data = 8'(8'hB0 + i);
      tick();
      chk($sformatf("seq3_ov[%0d]", i),
          32'(b3.out_valid), 32'(1 << (i % 3)));
      chk($sformatf("seq3_od[%0d]", i),
          32'(b3.out_data[(i % 3)*8 +: 8]),
          32'(8'hB0 + i));
    end
    b3.in_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
